wb_ctrl: RTL

Writeback controller that drives the write port of the 4-entry, 9-bit register file in the ALU/register-file datapath. It merges single-cycle ALU results with variable-latency load responses from memory. It tracks registers with outstanding loads on a busy scoreboard and raises a stall for read-after-write, write-after-write and capacity hazards. It is the producer for the register file's wr_en/wr_addr/wr_data, which the ALU path consumes through its read ports.

---
 rtl/wb_ctrl.sv | 131 +++++++++++++
 1 files changed

// File: rtl/wb_ctrl.sv
// Writeback controller for the 4x9 register file: merges ALU results with in-order load
// responses, tracks outstanding loads per register and raises decode stalls on hazards.
module wb_ctrl #(
    parameter int unsigned LQ_DEPTH = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       alu_valid,
    input  logic [1:0] alu_dst,
    input  logic [7:0] alu_f,
    input  logic       alu_ovf,
    input  logic       ld_issue,
    input  logic [1:0] ld_dst,
    input  logic       ld_valid,
    output logic       ld_ready,
    input  logic [7:0] ld_data,
    input  logic [1:0] rd0_addr,
    input  logic [1:0] rd1_addr,
    output logic       stall,
    output logic [3:0] busy,
    output logic       wr_en,
    output logic [1:0] wr_addr,
    output logic [8:0] wr_data,
    output logic       err
);

    localparam int unsigned AddrW = (LQ_DEPTH > 1) ? $clog2(LQ_DEPTH) : 1;
    localparam logic [AddrW:0] PtrOne = 1;

    logic [1:0] tag_mem  [LQ_DEPTH];
    logic [9:0] resp_mem [LQ_DEPTH];

    logic [AddrW:0] tag_wptr_q, tag_rptr_q, resp_wptr_q, resp_rptr_q;
    logic [3:0]     busy_q, busy_d;
    logic           wr_en_q, wr_en_d, wr_ld_q, wr_ld_d, err_q, err_d;
    logic [1:0]     wr_addr_q, wr_addr_d;
    logic [8:0]     wr_data_q, wr_data_d;

    logic       tag_empty, tag_full, resp_empty, resp_full;
    logic       ld_accept, ld_hs, alu_win, resp_pop, tag_pop;
    logic [9:0] resp_head;

    // Extra pointer bit distinguishes full from empty when the index bits match.
    assign tag_empty  = (tag_wptr_q == tag_rptr_q);
    assign tag_full   = (tag_wptr_q[AddrW] != tag_rptr_q[AddrW]) &&
                        (tag_wptr_q[AddrW-1:0] == tag_rptr_q[AddrW-1:0]);
    assign resp_empty = (resp_wptr_q == resp_rptr_q);
    assign resp_full  = (resp_wptr_q[AddrW] != resp_rptr_q[AddrW]) &&
                        (resp_wptr_q[AddrW-1:0] == resp_rptr_q[AddrW-1:0]);
    assign resp_head  = resp_mem[resp_rptr_q[AddrW-1:0]];
    assign tag_pop    = ld_hs && !tag_empty;

    always_comb begin
        ld_ready  = 1'b0;
        ld_accept = 1'b0;
        ld_hs     = 1'b0;
        alu_win   = 1'b0;
        resp_pop  = 1'b0;
        stall     = 1'b0;
        if (!rst) begin
            ld_ready  = !resp_full;
            ld_accept = ld_issue && !tag_full && !busy_q[ld_dst];
            ld_hs     = ld_valid && !resp_full;
            alu_win   = alu_valid && !resp_full && !busy_q[alu_dst];
            resp_pop  = !alu_win && !resp_empty;
            stall     = busy_q[rd0_addr] | busy_q[rd1_addr] |
                        (ld_issue && !ld_accept) | (alu_valid && !alu_win);
        end
    end

    always_comb begin
        busy_d    = busy_q;
        err_d     = err_q | (ld_hs && tag_empty);
        wr_en_d   = alu_win | resp_pop;
        wr_ld_d   = resp_pop;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        // The busy bit drops only once the load value has actually been committed.
        if (wr_en_q && wr_ld_q) begin
            busy_d[wr_addr_q] = 1'b0;
        end
        if (ld_accept) begin
            busy_d[ld_dst] = 1'b1;
        end
        if (resp_pop) begin
            wr_addr_d = resp_head[9:8];
            wr_data_d = {1'b0, resp_head[7:0]};
        end else if (alu_win) begin
            wr_addr_d = alu_dst;
            wr_data_d = {alu_ovf, alu_f};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tag_wptr_q  <= '0;
            tag_rptr_q  <= '0;
            resp_wptr_q <= '0;
            resp_rptr_q <= '0;
            busy_q      <= '0;
            wr_en_q     <= 1'b0;
            wr_ld_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            err_q       <= 1'b0;
        end else begin
            if (ld_accept) tag_wptr_q  <= tag_wptr_q + PtrOne;
            if (tag_pop)   tag_rptr_q  <= tag_rptr_q + PtrOne;
            if (tag_pop)   resp_wptr_q <= resp_wptr_q + PtrOne;
            if (resp_pop)  resp_rptr_q <= resp_rptr_q + PtrOne;
            busy_q    <= busy_d;
            wr_en_q   <= wr_en_d;
            wr_ld_q   <= wr_ld_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            err_q     <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (ld_accept) tag_mem[tag_wptr_q[AddrW-1:0]] <= ld_dst;
        if (tag_pop) resp_mem[resp_wptr_q[AddrW-1:0]] <= {tag_mem[tag_rptr_q[AddrW-1:0]], ld_data};
    end

    assign busy    = busy_q;
    assign wr_en   = wr_en_q;
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;
    assign err     = err_q;

endmodule
